// File: rtl/pipeline_hazard_controller.sv
// Hazard and stall sequencer for a 5-stage MIPS pipeline: forwarding selects, load-use
// stalls, branch flushes and a memory-busy freeze with a sticky timeout error.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic [4:0]       IDEX_rs,
  input  logic [4:0]       IDEX_rt,
  input  logic             IDEX_memRead,
  input  logic             EXMEM_regWrite,
  input  logic [4:0]       EXMEM_rd,
  input  logic             MEMWB_regWrite,
  input  logic [4:0]       MEMWB_rd,
  input  logic             branchTaken,
  input  logic             memReq,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             idexWrite,
  output logic             exmemWrite,
  output logic             idexBubble,
  output logic             ifidFlush,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             memError,
  output logic [CNT_W-1:0] stallCycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [7:0]       wait_inc;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             load_use;
  logic             freeze;
  logic             run_decode;
  logic [1:0]       fwd_a, fwd_b;

  assign load_use = IDEX_memRead && (IDEX_rt != 5'd0) &&
                    ((IDEX_rt == ID_rs) || (IDEX_rt == ID_rt));
  assign wait_inc = wait_cnt_q + 8'd1;

  // EX/MEM result is newer than MEM/WB, so it takes priority.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (EXMEM_regWrite && (EXMEM_rd != 5'd0) && (EXMEM_rd == IDEX_rs))
      fwd_a = 2'b10;
    else if (MEMWB_regWrite && (MEMWB_rd != 5'd0) && (MEMWB_rd == IDEX_rs))
      fwd_a = 2'b01;
    if (EXMEM_regWrite && (EXMEM_rd != 5'd0) && (EXMEM_rd == IDEX_rt))
      fwd_b = 2'b10;
    else if (MEMWB_regWrite && (MEMWB_rd != 5'd0) && (MEMWB_rd == IDEX_rt))
      fwd_b = 2'b01;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    run_decode = 1'b0;
    case (state_q)
      RUN: begin
        if (memReq && !memReady) begin
          freeze     = 1'b1;
          wait_cnt_d = 8'd1;
          state_d    = (TIMEOUT_CNT <= 8'd1) ? ERROR : MEM_WAIT;
        end else begin
          run_decode = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (memReady) begin
          run_decode = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = RUN;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_inc;
          if (wait_inc >= TIMEOUT_CNT) state_d = ERROR;
        end
      end
      ERROR:   freeze = 1'b1;
      default: state_d = RUN;
    endcase
  end

  // Enable priority: reset > freeze > branch flush > load-use stall.
  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    idexWrite  = 1'b1;
    exmemWrite = 1'b1;
    idexBubble = 1'b0;
    ifidFlush  = 1'b0;
    forwardA   = fwd_a;
    forwardB   = fwd_b;
    if (Reset) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexWrite  = 1'b0;
      exmemWrite = 1'b0;
      idexBubble = 1'b1;
      forwardA   = 2'b00;
      forwardB   = 2'b00;
    end else if (freeze) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexWrite  = 1'b0;
      exmemWrite = 1'b0;
    end else if (run_decode && branchTaken) begin
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end else if (run_decode && load_use) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pcWrite && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= RUN;
      wait_cnt_q     <= 8'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign memError    = (state_q == ERROR);
  assign stallCycles = stall_cycles_q;

endmodule
